sccb_master: RTL
================

# sccb_master

Parametrised SCCB master for OV-series camera configuration: performs 3-phase register writes and 2-phase-write + 2-phase-read register reads on an open-drain SIOC/SIOD pair. It sits between the camera init/config sequencer and the pad-level open-drain drivers (oe=1 pulls the line low). It adds read support, ACK checking, 16-bit register addressing and an explicit completion pulse.

## Interface
- CLK_FREQ, 25000000, system clock frequency in Hz
- SCCB_FREQ, 100000, SIOC frequency in Hz
- DEV_ADDR, 8'h42, 8-bit device write address (bit0=0); read uses DEV_ADDR|1
- ADDR_BYTES, 1, register address bytes (1 or 2), sent MSB byte first

- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only on a cycle with ready=1
- rw  in  1  0=write, 1=read; latched on accept
- address  in  8*ADDR_BYTES  register address; latched on accept
- wdata  in  8  write data; latched on accept
- SIOD_in  in  1  sampled SIOD pad level (already synchronised)
- ready  out  1  idle, can accept start
- done  out  1  one-cycle completion pulse
- rdata  out  8  last read byte
- ack_err  out  1  NACK seen on any master-written byte of the last transaction
- SIOC_oe  out  1  1 = pull SIOC low
- SIOD_oe  out  1  1 = pull SIOD low

## Operation
- Q = CLK_FREQ/(4*SCCB_FREQ), integer division; legal only for Q>=2 (defaults: Q=62).
- Reset: SIOC_oe=0, SIOD_oe=0, ready=1, done=0, ack_err=0, rdata=0, FSM=IDLE. rst mid-transaction aborts at the next edge with the same values (lines released, no stop generated).
- States: IDLE, START, BIT (sub-phases LOW, DATA, HIGH), STOP (4 sub-phases), GAP, DONE; a phase timer sequences each phase.
- IDLE: both lines released. On start&ready: latch inputs, clear ack_err, ready=0, enter START.
- START: SIOD_oe=1 with SIOC released, hold Q cycles.
- BIT (per bit, MSB first, 9 bits per byte, 4Q cycles total): LOW: SIOC_oe=1 for Q; DATA: SIOD_oe=~bit (bit 9 of a written byte and all 9 bits of a read byte: SIOD_oe=0) for Q; HIGH: SIOC_oe=0 for 2Q. Sample SIOD_in on the last cycle of the first Q of HIGH.
- Bit-9 sample of a written byte =1 sets ack_err (sticky until next accept); the transaction continues regardless.
- Read-byte bits 1-8 sampled into a shift register; the 9th bit is master NA (released).
- STOP: SIOC_oe=1 (Q), SIOD_oe=1 (Q), SIOC_oe=0 (Q), SIOD_oe=0 (Q).
- GAP: both released, 8Q cycles.
- Write: START, DEV_ADDR, address bytes, wdata, STOP, GAP, DONE.
- Read: START, DEV_ADDR, address bytes, STOP, GAP, START, DEV_ADDR|1, read byte, STOP, GAP, DONE.
- DONE: ready=1, done=1 for one cycle; rdata updated from the shift register (reads only, otherwise held). A start that is high in this cycle is accepted.
- start while ready=0 is ignored (not queued).

## Timing
- Every phase lasts exactly its stated cycle count; output changes take effect on the first cycle of the phase.
- ready is low for exactly T cycles after the accept edge; done and ready=1 coincide in the following cycle.
- T_write = (13 + 36*(2+ADDR_BYTES))*Q; default = 121Q = 7502 cycles.
- T_read = (98 + 36*(1+ADDR_BYTES))*Q; default = 170Q = 10540 cycles.
- start held continuously: back-to-back transactions, with one ready=1 cycle (the DONE cycle) between them.
- SIOD changes only while SIOC is low, except START/STOP edges.

## Test plan
- Write, defaults, address=8'h12, wdata=8'h80, slave ACKs -> SIOD bytes 0x42, 0x12, 0x80 decoded on SIOC rising edges; ready low 7502 cycles; single done pulse; ack_err=0.
- Read, address=8'h0A, slave model drives 0x76 -> first phase 0x42, 0x0A then STOP; second phase 0x43, master NA; rdata=8'h76 at done; ready low 10540 cycles.
- Write with SIOD_in held high (no slave) -> full transaction completes, ack_err=1 at done; next accepted start clears ack_err.
- ADDR_BYTES=2, write address=16'h3012, wdata=8'h55 -> bytes 0x42, 0x30, 0x12, 0x55; ready low 157Q = 9734 cycles.
- rst asserted 3000 cycles into a write -> next cycle SIOC_oe=0, SIOD_oe=0, ready=1, done=0; a new start works normally.
- start pulsed again mid-transaction and held high through done -> mid pulse ignored; exactly one new transaction begins at the DONE cycle.

Source files
------------

// File: rtl/sccb_if.sv
// Host and pad-side signal bundle of the SCCB master.
// The master modport is the controller's view; the slave modport is the sequencer/pad side.
interface sccb_if #(
  parameter int ADDR_BYTES = 1
) ();
  logic                    start;
  logic                    rw;
  logic [8*ADDR_BYTES-1:0] address;
  logic [7:0]              wdata;
  logic                    SIOD_in;
  logic                    ready;
  logic                    done;
  logic [7:0]              rdata;
  logic                    ack_err;
  logic                    SIOC_oe;
  logic                    SIOD_oe;

  modport master (
    input  start, rw, address, wdata, SIOD_in,
    output ready, done, rdata, ack_err, SIOC_oe, SIOD_oe
  );

  modport slave (
    output start, rw, address, wdata, SIOD_in,
    input  ready, done, rdata, ack_err, SIOC_oe, SIOD_oe
  );
endinterface

// File: rtl/sccb_master.sv
// SCCB master: 3-phase register writes and 2-phase write + 2-phase read register reads
// on an open-drain SIOC/SIOD pair, with ACK checking and a one-cycle completion pulse.
module sccb_master #(
  parameter int         CLK_FREQ   = 25000000,
  parameter int         SCCB_FREQ  = 100000,
  parameter logic [7:0] DEV_ADDR   = 8'h42,
  parameter int         ADDR_BYTES = 1
) (
  input logic   clk,
  input logic   rst,
  sccb_if.master bus
);

  localparam int Q       = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int GAP_CYC = 8 * Q;
  localparam int TW      = $clog2(GAP_CYC);
  localparam logic [TW-1:0] Q_M1   = TW'(Q - 1);
  localparam logic [TW-1:0] GAP_M1 = TW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_STOP,
    S_GAP,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [1:0]              sub_q, sub_d;
  logic [3:0]              bit_q, bit_d;
  logic [1:0]              byte_q, byte_d;
  logic [8:0]              tx_q, tx_d;
  logic [7:0]              rx_q, rx_d;
  logic                    phase2_q, phase2_d;
  logic                    rw_q, rw_d;
  logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic                    sioc_oe_q, sioc_oe_d;
  logic                    siod_oe_q, siod_oe_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    ack_err_q, ack_err_d;
  logic [7:0]              rdata_q, rdata_d;

  logic       timer_done;
  logic       is_rd_byte;
  logic [1:0] last_idx;
  logic [1:0] next_idx;

  // Byte sent at position idx of the current segment; the read byte is all ones so SIOD stays released.
  function automatic logic [7:0] byte_at(input logic [1:0] idx, input logic p2,
                                         input logic [8*ADDR_BYTES-1:0] a, input logic [7:0] wd);
    if (idx == 2'd0)                return p2 ? (DEV_ADDR | 8'h01) : DEV_ADDR;
    else if (p2)                    return 8'hFF;
    else if (int'(idx) <= ADDR_BYTES) return a[8*(ADDR_BYTES-int'(idx)) +: 8];
    else                            return wd;
  endfunction

  assign timer_done = (timer_q == '0);
  assign is_rd_byte = phase2_q && (byte_q == 2'd1);
  assign last_idx   = phase2_q ? 2'd1 : (rw_q ? 2'(ADDR_BYTES) : 2'(ADDR_BYTES + 1));
  assign next_idx   = byte_q + 2'd1;

  always_comb begin
    // NOTE: every _d gets a default first, so no path through this block can infer a latch.
    state_d   = state_q;
    timer_d   = timer_done ? timer_q : timer_q - TW'(1);
    sub_d     = sub_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    phase2_d  = phase2_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sioc_oe_d = sioc_oe_q;
    siod_oe_d = siod_oe_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start && ready_q) begin
          state_d   = S_START;
          timer_d   = Q_M1;
          rw_d      = bus.rw;
          addr_d    = bus.address;
          wdata_d   = bus.wdata;
          phase2_d  = 1'b0;
          byte_d    = 2'd0;
          ack_err_d = 1'b0;
          ready_d   = 1'b0;
          sioc_oe_d = 1'b0;
          siod_oe_d = 1'b1;
        end
      end

      S_START: begin
        if (timer_done) begin
          state_d   = S_BIT;
          timer_d   = Q_M1;
          sub_d     = 2'd0;
          bit_d     = 4'd0;
          tx_d      = {byte_at(byte_q, phase2_q, addr_q, wdata_q), 1'b1};
          sioc_oe_d = 1'b1;
        end
      end

      S_BIT: begin
        if (timer_done) begin
          timer_d = Q_M1;
          unique case (sub_q)
            2'd0: begin
              sub_d     = 2'd1;
              siod_oe_d = ~tx_q[8];
            end
            2'd1: begin
              sub_d     = 2'd2;
              sioc_oe_d = 1'b0;
            end
            2'd2: begin
              // End of the first half of SIOC high: the slave's bit is stable here.
              sub_d = 2'd3;
              if (bit_q == 4'd8) begin
                if (!is_rd_byte && bus.SIOD_in) ack_err_d = 1'b1;
              end else if (is_rd_byte) begin
                rx_d = {rx_q[6:0], bus.SIOD_in};
              end
            end
            default: begin
              sub_d     = 2'd0;
              sioc_oe_d = 1'b1;
              if (bit_q != 4'd8) begin
                bit_d = bit_q + 4'd1;
                tx_d  = {tx_q[7:0], 1'b0};
              end else if (byte_q != last_idx) begin
                byte_d = next_idx;
                bit_d  = 4'd0;
                tx_d   = {byte_at(next_idx, phase2_q, addr_q, wdata_q), 1'b1};
              end else begin
                state_d = S_STOP;
              end
            end
          endcase
        end
      end

      S_STOP: begin
        if (timer_done) begin
          timer_d = Q_M1;
          unique case (sub_q)
            2'd0: begin
              sub_d     = 2'd1;
              siod_oe_d = 1'b1;
            end
            2'd1: begin
              sub_d     = 2'd2;
              sioc_oe_d = 1'b0;
            end
            2'd2: begin
              sub_d     = 2'd3;
              siod_oe_d = 1'b0;
            end
            default: begin
              state_d = S_GAP;
              timer_d = GAP_M1;
            end
          endcase
        end
      end

      S_GAP: begin
        if (timer_done) begin
          if (rw_q && !phase2_q) begin
            state_d   = S_START;
            timer_d   = Q_M1;
            phase2_d  = 1'b1;
            byte_d    = 2'd0;
            siod_oe_d = 1'b1;
          end else begin
            state_d = S_DONE;
            ready_d = 1'b1;
            done_d  = 1'b1;
            if (rw_q) rdata_d = rx_q;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with nonblocking assignments only, so every flop sees pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      sub_q     <= 2'd0;
      bit_q     <= 4'd0;
      byte_q    <= 2'd0;
      tx_q      <= '0;
      rx_q      <= '0;
      phase2_q  <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sioc_oe_q <= 1'b0;
      siod_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sub_q     <= sub_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      phase2_q  <= phase2_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sioc_oe_q <= sioc_oe_d;
      siod_oe_q <= siod_oe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.SIOC_oe = sioc_oe_q;
  assign bus.SIOD_oe = siod_oe_q;
  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.ack_err = ack_err_q;
  assign bus.rdata   = rdata_q;

endmodule
